// File: rtl/serial_subtractor_pkg.sv
// serial_subtractor_pkg: shared state encoding and counter sizing for the bit-serial subtractor
package serial_subtractor_pkg;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;
  function automatic int cnt_width(input int w);
    return ($clog2(w) < 1) ? 1 : $clog2(w);
  endfunction
endpackage

// File: rtl/serial_subtractor_full_adder_b.sv
// full_adder_b: single-bit full adder cell shared by the serial arithmetic blocks
module full_adder_b (
  input  logic a,
  input  logic b,
  input  logic c0,
  output logic s,
  output logic c
);
  assign s = a ^ b ^ c0;
  assign c = (a & b) | (a & c0) | (b & c0);
endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor: LSB-first a - b using one full adder on ~b with carry preset to 1
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             overflow
);
  localparam int CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);
  state_t           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d, sb_q, sb_d, res_q, res_d, diff_q, diff_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d, sa_msb_q, sa_msb_d, sb_msb_q, sb_msb_d;
  logic             busy_q, busy_d, done_q, done_d, borrow_q, borrow_d, ovf_q, ovf_d;
  logic             nb, s_bit, c_out;
  assign nb = ~sb_q[0];
  full_adder_b u_fa (
    .a  (sa_q[0]),
    .b  (nb),
    .c0 (carry_q),
    .s  (s_bit),
    .c  (c_out)
  );
  // next-state: accept in IDLE, one bit per RUN edge, publish results on the last bit
  always_comb begin
    state_d  = state_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    res_d    = res_q;
    diff_d   = diff_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    sa_msb_d = sa_msb_q;
    sb_msb_d = sb_msb_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    borrow_d = borrow_q;
    ovf_d    = ovf_q;
    case (state_q)
      ST_IDLE: if (start) begin
        state_d  = ST_RUN;
        sa_d     = a;
        sb_d     = b;
        res_d    = '0;
        cnt_d    = '0;
        carry_d  = 1'b1;
        sa_msb_d = a[WIDTH-1];
        sb_msb_d = b[WIDTH-1];
        busy_d   = 1'b1;
      end
      ST_RUN: begin
        sa_d    = sa_q >> 1;
        sb_d    = sb_q >> 1;
        res_d   = {s_bit, res_q[WIDTH-1:1]};
        carry_d = c_out;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d  = ST_DONE;
          diff_d   = {s_bit, res_q[WIDTH-1:1]};
          borrow_d = ~c_out;
          ovf_d    = (sa_msb_q != sb_msb_q) && (s_bit != sa_msb_q);
          done_d   = 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end
  // state and registered outputs; reset clears everything and aborts a run in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      sa_q     <= '0;
      sb_q     <= '0;
      res_q    <= '0;
      diff_q   <= '0;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      sa_msb_q <= 1'b0;
      sb_msb_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      borrow_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      res_q    <= res_d;
      diff_q   <= diff_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      sa_msb_q <= sa_msb_d;
      sb_msb_q <= sb_msb_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      borrow_q <= borrow_d;
      ovf_q    <= ovf_d;
    end
  end
  assign busy     = busy_q;
  assign done     = done_q;
  assign diff     = diff_q;
  assign borrow   = borrow_q;
  assign overflow = ovf_q;
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed and random operations checked against plain integer arithmetic
module tb_serial_subtractor;
  localparam int W = 8;
  logic         clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic         busy, done, borrow, overflow;
  logic [W-1:0] diff;
  int           nvec = 0, nerr = 0;
  logic [W-1:0] hd = '0;
  logic         hb = 1'b0, ho = 1'b0;
  always #5 clk = ~clk;
  serial_subtractor #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .diff     (diff),
    .borrow   (borrow),
    .overflow (overflow)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic op(input logic [W-1:0] av, input logic [W-1:0] bv, input bit poke);
    int lat, sd;
    logic [W-1:0] ed;
    logic eb, eo;
    ed = av - bv;
    eb = av < bv;
    sd = int'($signed(av)) - int'($signed(bv));
    eo = (sd > 127) || (sd < -128);
    @(negedge clk);
    a = av;
    b = bv;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
    lat = 0;
    while (!done && lat < 3 * W) begin
      chk("busy_run", busy, 1);
      chk("diff_hold", diff, hd);
      chk("borrow_hold", borrow, hb);
      chk("ovf_hold", overflow, ho);
      if (poke && lat == 3) begin
        start = 1'b1;
        a = 8'h11;
        b = 8'h11;
      end else start = 1'b0;
      @(posedge clk);
      #1;
      lat++;
    end
    start = 1'b0;
    chk("latency", lat, W);
    chk("diff", diff, ed);
    chk("borrow", borrow, eb);
    chk("overflow", overflow, eo);
    chk("busy_done", busy, 1);
    hd = ed;
    hb = eb;
    ho = eo;
    @(posedge clk);
    #1;
    chk("done_pulse", done, 0);
    chk("busy_idle", busy, 0);
    chk("diff_after", diff, hd);
  endtask
  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_diff", diff, 0);
    chk("rst_borrow", borrow, 0);
    chk("rst_ovf", overflow, 0);
    rst = 1'b0;
    op(8'h05, 8'h03, 0);
    op(8'h03, 8'h05, 0);
    op(8'h80, 8'h01, 0);
    op(8'h7F, 8'hFF, 0);
    op(8'h00, 8'h00, 0);
    op(8'hAA, 8'h55, 1);
    op(8'h3C, 8'h3C, 0);
    op(8'h9E, 8'h00, 0);
    @(negedge clk);
    a = 8'h10;
    b = 8'h01;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_diff", diff, 0);
    chk("abort_borrow", borrow, 0);
    chk("abort_ovf", overflow, 0);
    hd = '0;
    hb = 1'b0;
    ho = 1'b0;
    repeat (12) begin
      @(posedge clk);
      #1;
      chk("abort_no_done", done, 0);
      chk("abort_idle", busy, 0);
    end
    op(8'h10, 8'h01, 0);
    repeat (30) op(W'($urandom), W'($urandom), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
